// File: rtl/tb_rd_memory_pkg.sv
// Shared types and helpers for the multi-channel bench read memory.
// Channel state, captured channel config and the address-to-index helper.
package tb_rd_memory_pkg;

  localparam int CfgAddrW = 32;
  localparam int MemDepthP = 1024;
  localparam int IdxW = $clog2(MemDepthP);

  typedef enum logic {
    ChIdle,
    ChRun
  } chan_state_e;

  typedef struct packed {
    logic [CfgAddrW-1:0] base;
    logic [CfgAddrW-1:0] stride;
    logic [CfgAddrW-1:0] len;
    logic                loop_en;
  } chan_cfg_t;

  function automatic logic [IdxW-1:0] idx(
    input logic [CfgAddrW-1:0] addr
  );
    return addr[IdxW-1:0];
  endfunction

endpackage

// File: rtl/tb_rd_memory_agen.sv
// One read channel: address generator, pass/loop counters and the
// registered valid/ready output stage.
module tb_rd_memory_agen
  import tb_rd_memory_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int AddrWidth    = 32,
  parameter int LoopCntWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic [AddrWidth-1:0]    base,
  input  logic [AddrWidth-1:0]    stride,
  input  logic [AddrWidth-1:0]    len,
  input  logic                    loop_en,
  input  logic                    ready,
  input  logic [DataWidth-1:0]    fetch_data,
  output logic [AddrWidth-1:0]    fetch_addr,
  output logic                    busy,
  output logic                    done,
  output logic [LoopCntWidth-1:0] loop_cnt,
  output logic [AddrWidth-1:0]    addr,
  output logic [DataWidth-1:0]    data,
  output logic                    valid
);

  chan_state_e             state_q, state_d;
  chan_cfg_t               cfg_q, cfg_d;
  logic [AddrWidth-1:0]    addr_q, addr_d;
  logic [AddrWidth-1:0]    cnt_q, cnt_d;
  logic [LoopCntWidth-1:0] lc_q, lc_d;
  logic [DataWidth-1:0]    data_q;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    ld;

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    lc_d    = lc_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    ld      = 1'b0;
    if (stop) begin
      state_d = ChIdle;
      valid_d = 1'b0;
    end else if (start) begin
      if (len != '0) begin
        cfg_d.base    = base;
        cfg_d.stride  = stride;
        cfg_d.len     = len;
        cfg_d.loop_en = loop_en;
        addr_d  = base;
        cnt_d   = '0;
        lc_d    = '0;
        valid_d = 1'b1;
        ld      = 1'b1;
        state_d = ChRun;
      end else begin
        state_d = ChIdle;
        valid_d = 1'b0;
        done_d  = 1'b1;
      end
    end else if (state_q == ChRun && valid_q && ready) begin
      if (cnt_q == cfg_q.len - 1'b1) begin
        if (cfg_q.loop_en) begin
          addr_d = cfg_q.base;
          cnt_d  = '0;
          ld     = 1'b1;
          if (lc_q != '1) lc_d = lc_q + 1'b1;
        end else begin
          valid_d = 1'b0;
          state_d = ChIdle;
          done_d  = 1'b1;
        end
      end else begin
        addr_d = addr_q + cfg_q.stride;
        cnt_d  = cnt_q + 1'b1;
        ld     = 1'b1;
      end
    end
  end

  // Memory is read at the address being loaded, before any same-edge write.
  assign fetch_addr = addr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ChIdle;
      cfg_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      lc_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      lc_q    <= lc_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      if (ld) data_q <= fetch_data;
    end
  end

  assign busy     = (state_q == ChRun);
  assign done     = done_q;
  assign loop_cnt = lc_q;
  assign addr     = addr_q;
  assign data     = data_q;
  assign valid    = valid_q;

endmodule

// File: rtl/tb_rd_memory_mc.sv
// Shared bench memory with a write/debug port and NumChannels
// independent streaming read channels.
module tb_rd_memory_mc
  import tb_rd_memory_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int AddrWidth    = 32,
  parameter int MemDepth     = 1024,
  parameter int NumChannels  = 2,
  parameter int LoopCntWidth = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                wr_en_i,
  input  logic [AddrWidth-1:0]                wr_addr_i,
  input  logic [DataWidth-1:0]                wr_data_i,
  input  logic [AddrWidth-1:0]                rd_addr_i,
  output logic [DataWidth-1:0]                rd_data_o,
  input  logic [NumChannels-1:0]              start_i,
  input  logic [NumChannels-1:0]              stop_i,
  input  logic [NumChannels*AddrWidth-1:0]    base_addr_i,
  input  logic [NumChannels*AddrWidth-1:0]    stride_i,
  input  logic [NumChannels*AddrWidth-1:0]    len_i,
  input  logic [NumChannels-1:0]              loop_en_i,
  output logic [NumChannels-1:0]              busy_o,
  output logic [NumChannels-1:0]              done_o,
  output logic [NumChannels*LoopCntWidth-1:0] loop_cnt_o,
  output logic [NumChannels*AddrWidth-1:0]    acc_addr_o,
  output logic [NumChannels*DataWidth-1:0]    acc_data_o,
  output logic [NumChannels-1:0]              acc_valid_o,
  input  logic [NumChannels-1:0]              acc_ready_i
);

  logic [DataWidth-1:0] mem [MemDepth];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MemDepth; i++) mem[i] <= '0;
    end else if (wr_en_i) begin
      mem[idx(wr_addr_i)] <= wr_data_i;
    end
  end

  assign rd_data_o = mem[idx(rd_addr_i)];

  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    logic [AddrWidth-1:0] fetch_addr;
    logic [DataWidth-1:0] fetch_data;

    assign fetch_data = mem[idx(fetch_addr)];

    tb_rd_memory_agen #(
      .DataWidth   (DataWidth),
      .AddrWidth   (AddrWidth),
      .LoopCntWidth(LoopCntWidth)
    ) u_agen (
      .clk       (clk_i),
      .rst       (rst_i),
      .start     (start_i[c]),
      .stop      (stop_i[c]),
      .base      (base_addr_i[c*AddrWidth +: AddrWidth]),
      .stride    (stride_i[c*AddrWidth +: AddrWidth]),
      .len       (len_i[c*AddrWidth +: AddrWidth]),
      .loop_en   (loop_en_i[c]),
      .ready     (acc_ready_i[c]),
      .fetch_data(fetch_data),
      .fetch_addr(fetch_addr),
      .busy      (busy_o[c]),
      .done      (done_o[c]),
      .loop_cnt  (loop_cnt_o[c*LoopCntWidth +: LoopCntWidth]),
      .addr      (acc_addr_o[c*AddrWidth +: AddrWidth]),
      .data      (acc_data_o[c*DataWidth +: DataWidth]),
      .valid     (acc_valid_o[c])
    );
  end

endmodule

// File: doc/tb_rd_memory_mc.md
Name: tb_rd_memory_mc

Overview:
- Multi-channel testbench read memory: one shared backing array written and inspected by the bench; NumChannels independent streaming read channels feed the accelerator.
- Each channel has its own address generator: programmable base, signed stride, length and loop mode.
- Each channel has a registered valid/ready output with full throughput under backpressure.
- Drop-in stimulus source for multi-operand accelerator benches: item memory, query and training streams read concurrently.

Parameters:
DataWidth, 32, word width
AddrWidth, 32, address/stride/length width
MemDepth, 1024, words; power of 2; IdxW = $clog2(MemDepth)
NumChannels, 2, independent read channels (>=1)
LoopCntWidth, 16, per-channel wrap counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
wr_en_i  in  1  bench write enable
wr_addr_i  in  AddrWidth  bench write address
wr_data_i  in  DataWidth  bench write data
rd_addr_i  in  AddrWidth  bench debug read address
rd_data_o  out  DataWidth  combinational mem[rd_addr_i[IdxW-1:0]]
start_i  in  NumChannels  per-channel start pulse
stop_i  in  NumChannels  per-channel abort pulse
base_addr_i  in  NumChannels x AddrWidth  start address, sampled on start
stride_i  in  NumChannels x AddrWidth  signed two's-complement stride, sampled on start
len_i  in  NumChannels x AddrWidth  words per pass, sampled on start
loop_en_i  in  NumChannels  restart at base after last word, sampled on start
busy_o  out  NumChannels  channel in RUN
done_o  out  NumChannels  1-cycle pulse at completion
loop_cnt_o  out  NumChannels x LoopCntWidth  completed passes in loop mode
acc_addr_o  out  NumChannels x AddrWidth  address of word currently presented
acc_data_o  out  NumChannels x DataWidth  registered data
acc_valid_o  out  NumChannels  data valid
acc_ready_i  in  NumChannels  consumer ready

Behaviour:
- Reset (asynchronous, active-high):
  - Memory cleared to 0.
  - All channels IDLE.
  - All outputs 0, except rd_data_o, which is combinational and therefore 0.
- Bench write: mem[wr_addr_i[IdxW-1:0]] <= wr_data_i at the clock edge.
- Memory indexing: upper address bits are ignored, so addresses wrap modulo MemDepth.
- Channel FSM has two states, IDLE and RUN. Registers: addr_q, cnt_q, data_q, valid_q, loop_cnt_q.
- IDLE + start_i, len_i != 0, at edge T:
  - addr_q <= base; cnt_q <= 0; loop_cnt_q <= 0.
  - data_q <= mem[base]; valid_q <= 1; state -> RUN.
  - Result: valid is visible in the cycle after the start pulse (1-cycle latency).
- IDLE + start_i, len_i == 0: stay IDLE, done_o pulses next cycle, no valid.
- RUN, handshake (valid & ready), cnt_q < len-1:
  - addr_q <= addr_q + stride, modulo 2^AddrWidth.
  - data_q <= mem[new addr]; cnt_q++.
  - valid stays high, giving one word per cycle.
- RUN, handshake on last word (cnt_q == len-1):
  - Loop mode: addr_q <= base, cnt_q <= 0, loop_cnt_q++ (saturating at all-ones), data_q <= mem[base].
  - Otherwise: valid_q <= 0, state -> IDLE, done_o = 1 for exactly one cycle.
- RUN, no handshake: every channel register holds. acc_addr_o and acc_data_o stay stable while valid & !ready.
- stop_i: state -> IDLE, valid_q <= 0 at the next edge, no done pulse. stop_i has priority over start_i and over a same-cycle handshake.
- start_i in RUN: restart with the new configuration, as if from IDLE. Any in-flight word is discarded, and that discard is legal.
- Read/write ordering: data_q samples memory before a same-edge write, so it gets the old data. A write to the address currently held in data_q does not refresh data_q.
- Channels are fully independent; any number may read the same address in one cycle.
- busy_o is high exactly while in RUN.
- Reset mid-stream: immediate return to the reset state; valid drops asynchronously.

Decomposition:
- Package tb_rd_memory_pkg holds:
  - chan_state_e {ChIdle, ChRun}
  - a chan_cfg_t struct {base, stride, len, loop_en}
  - the helper function idx(addr), which returns the low IdxW bits.
- Sub-module tb_rd_memory_agen holds one channel's FSM, counters and output register. The top instantiates NumChannels copies in a generate loop, with the shared memory array and write port in the top.

Test Plan:
- Write mem[i]=i+100 for i=0..15; ch0 base=2 stride=3 len=4, ready=1 -> data 102,105,108,111 on consecutive cycles; done_o pulses once; busy_o drops.
- ch1 stride=-1 (all ones) base=1 len=3 -> addresses 1, 0, MemDepth-1 (wrap), i.e. data 101, 100, mem[1023].
- ch0 loop_en=1 base=0 stride=1 len=2 for 7 handshakes -> data 100,101,100,101,100,101,100; loop_cnt_o=3; no done.
- Random ready toggling on ch0 while ch1 streams at ready=1 -> addr/data stable during stalls; ch1 unaffected; every word delivered exactly once.
- stop_i asserted together with a handshake and with start_i -> valid low next cycle, no done, channel IDLE; len=0 start -> done pulse, valid never rises.
- Assert rst_i mid-stream after writing mem[5]=0xAB -> valid and busy drop immediately; rd_data_o at addr 5 reads 0; a restart works normally.
